// File: rtl/d5m_pkg.sv
// Shared types and constants for the D5M sensor pattern generator.
package d5m_pkg;

    localparam int PIX_W = 12;

    localparam logic [PIX_W-1:0] LFSR_SEED = 12'hACE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FSTART,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    typedef enum logic [1:0] {
        MODE_XRAMP   = 2'd0,
        MODE_YRAMP   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_LFSR    = 2'd3
    } mode_t;

endpackage

// File: rtl/patgen_lfsr12.sv
// 12-bit Fibonacci LFSR (x^12+x^6+x^4+x+1) for pattern mode 3.
// Only compiled when D5M_PATGEN_LFSR_EN is defined.
`ifdef D5M_PATGEN_LFSR_EN
module patgen_lfsr12
    import d5m_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    output logic [PIX_W-1:0] value
);

    logic fb;

    assign fb = value[11] ^ value[5] ^ value[3] ^ value[0];

    // Reload wins over advance so every frame replays the same sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else if (load) begin
            value <= LFSR_SEED;
        end else if (adv) begin
            value <= {value[10:0], fb};
        end
    end

endmodule
`endif

// File: rtl/d5m_pattern_gen.sv
// D5M sensor output emulator: FVAL/LVAL framing plus selectable test patterns.
// Define D5M_PATGEN_LFSR_EN to make mode 3 an LFSR; otherwise mode 3 is flat 12'h800.
module d5m_pattern_gen
    import d5m_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 160,
    parameter int V_BLANK  = 45
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iMODE,
    output logic [11:0] oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    localparam logic [15:0] H_ACT_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] V_ACT_LAST = 16'(V_ACTIVE - 1);
    localparam logic [15:0] H_BLK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] V_BLK_LAST = 16'(V_BLANK - 1);

    state_t           state, state_nx;
    mode_t            mode_q, mode_nx;
    logic [15:0]      cnt, cnt_nx;
    logic [15:0]      row, row_nx;
    logic             stop_pend, stop_nx;
    logic             fstart_entry;
    logic             fval_nx, lval_nx;
    logic [15:0]      x_nx, y_nx;
    logic [PIX_W-1:0] pix_nx;
    logic [PIX_W-1:0] mode3_pix;

    function automatic logic [PIX_W-1:0] pattern_pix(
        input mode_t            m,
        input logic [PIX_W-1:0] x,
        input logic [PIX_W-1:0] y,
        input logic [PIX_W-1:0] m3
    );
        logic [PIX_W-1:0] p;
        case (m)
            MODE_XRAMP:   p = x;
            MODE_YRAMP:   p = y;
            MODE_CHECKER: p = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
            default:      p = m3;
        endcase
        return p;
    endfunction

    // Next-state, counters and sticky stop request
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 16'd1;
        row_nx   = row;
        stop_nx  = stop_pend;
        if (state != ST_IDLE && iSTOP) begin
            stop_nx = 1'b1;
        end
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (iSTART) begin
                    state_nx = ST_FSTART;
                    stop_nx  = iSTOP;
                end
            end
            ST_FSTART: begin
                if (cnt == H_BLK_LAST) begin
                    state_nx = ST_ACTIVE;
                    cnt_nx   = '0;
                end
            end
            ST_ACTIVE: begin
                if (cnt == H_ACT_LAST) begin
                    state_nx = ST_HBLANK;
                    cnt_nx   = '0;
                end
            end
            ST_HBLANK: begin
                if (cnt == H_BLK_LAST) begin
                    cnt_nx = '0;
                    if (row == V_ACT_LAST) begin
                        state_nx = ST_VBLANK;
                        row_nx   = '0;
                    end else begin
                        state_nx = ST_ACTIVE;
                        row_nx   = row + 16'd1;
                    end
                end
            end
            ST_VBLANK: begin
                if (cnt == V_BLK_LAST) begin
                    cnt_nx   = '0;
                    state_nx = stop_pend ? ST_IDLE : ST_FSTART;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                row_nx   = '0;
            end
        endcase
        if (state_nx == ST_IDLE) begin
            stop_nx = 1'b0;
        end
    end

    // Outputs are computed from the next state so the registered copies line up with it
    always_comb begin
        fstart_entry = (state_nx == ST_FSTART) && (state != ST_FSTART);
        mode_nx      = fstart_entry ? mode_t'(iMODE) : mode_q;
        fval_nx      = (state_nx == ST_FSTART) || (state_nx == ST_ACTIVE) ||
                       (state_nx == ST_HBLANK);
        lval_nx      = (state_nx == ST_ACTIVE);
        x_nx         = lval_nx ? cnt_nx : 16'd0;
        y_nx         = fval_nx ? row_nx : 16'd0;
        pix_nx       = lval_nx ? pattern_pix(mode_nx, x_nx[11:0], y_nx[11:0], mode3_pix)
                               : 12'h000;
    end

`ifdef D5M_PATGEN_LFSR_EN
    patgen_lfsr12 u_lfsr (
        .clk   (iCLK),
        .rst_n (iRST_N),
        .load  (fstart_entry),
        .adv   (lval_nx),
        .value (mode3_pix)
    );
`else
    assign mode3_pix = 12'h800;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_XRAMP;
            cnt         <= '0;
            row         <= '0;
            stop_pend   <= 1'b0;
            oDATA       <= '0;
            oFVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Cont <= '0;
            oBUSY       <= 1'b0;
        end else begin
            state       <= state_nx;
            mode_q      <= mode_nx;
            cnt         <= cnt_nx;
            row         <= row_nx;
            stop_pend   <= stop_nx;
            oDATA       <= pix_nx;
            oFVAL       <= fval_nx;
            oLVAL       <= lval_nx;
            oX_Cont     <= x_nx;
            oY_Cont     <= y_nx;
            oBUSY       <= (state_nx != ST_IDLE);
            if (oFVAL && !fval_nx) begin
                oFrame_Cont <= oFrame_Cont + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_d5m_pattern_gen.sv
// Directed bench for d5m_pattern_gen on a reduced 8x4 geometry.
module tb_d5m_pattern_gen;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HB = 3;
    localparam int VB = 5;
    localparam int LP = HA + HB;
    localparam int FP = HB + VA * LP + VB;

    logic        iCLK   = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iSTART = 1'b0;
    logic        iSTOP  = 1'b0;
    logic [1:0]  iMODE  = 2'd0;
    logic [11:0] oDATA;
    logic        oFVAL;
    logic        oLVAL;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oBUSY;

    int n_checks = 0;
    int n_errors = 0;
    int frames   = 0;

    d5m_pattern_gen #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .V_BLANK  (VB)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iSTART      (iSTART),
        .iSTOP       (iSTOP),
        .iMODE       (iMODE),
        .oDATA       (oDATA),
        .oFVAL       (oFVAL),
        .oLVAL       (oLVAL),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oFrame_Cont (oFrame_Cont),
        .oBUSY       (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One full frame sampled on falling edges; k=0 is the first cycle with oFVAL high.
    task automatic run_frame(input int emode, input int stop_at, input int start_at,
                             input int mode_at, input logic [1:0] mode_new);
        int          fhigh   = 0;
        int          bursts  = 0;
        int          first_l = -1;
        logic        prev_l  = 1'b0;
        logic [11:0] lf      = 12'hACE;
        logic        e_f, e_l;
        int          e_x, e_y;
        logic [11:0] e_d;
        for (int k = 0; k < FP; k++) begin
            @(negedge iCLK);
            iSTART = (k == start_at);
            iSTOP  = (k == stop_at);
            if (k == mode_at) iMODE = mode_new;
            e_f = (k < FP - VB);
            e_l = e_f && (k >= HB) && (((k - HB) % LP) < HA);
            e_x = e_l ? (k - HB) % LP : 0;
            e_y = (e_f && k >= HB) ? (k - HB) / LP : 0;
            e_d = 12'h000;
            if (e_l) begin
                case (emode)
                    0: e_d = 12'(e_x);
                    1: e_d = 12'(e_y);
                    2: e_d = (((e_x >> 3) ^ (e_y >> 3)) & 1) != 0 ? 12'hFFF : 12'h000;
                    default: begin
`ifdef D5M_PATGEN_LFSR_EN
                        e_d = lf;
                        lf  = {lf[10:0], lf[11] ^ lf[5] ^ lf[3] ^ lf[0]};
`else
                        e_d = 12'h800;
`endif
                    end
                endcase
            end
            chk("fval_lval_busy", 32'({oFVAL, oLVAL, oBUSY}), 32'({e_f, e_l, 1'b1}));
            chk("x_cont", 32'(oX_Cont), 32'(e_x));
            chk("y_cont", 32'(oY_Cont), 32'(e_y));
            chk("data", 32'(oDATA), 32'(e_d));
            if (k == FP - VB) begin
                frames++;
                chk("frame_cont", oFrame_Cont, 32'(frames));
            end
            fhigh += int'(oFVAL);
            if (oLVAL && !prev_l) begin
                bursts++;
                if (first_l < 0) first_l = k;
            end
            prev_l = oLVAL;
        end
        chk("fval_high_cycles", 32'(fhigh), 32'(FP - VB));
        chk("lval_bursts", 32'(bursts), 32'(VA));
        chk("first_lval_delay", 32'(first_l), 32'(HB));
    endtask

    task automatic idle_check(input int n);
        int fv = 0;
        int bz = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            fv += int'(oFVAL);
            bz += int'(oBUSY);
        end
        chk("idle_fval_cycles", 32'(fv), 32'd0);
        chk("idle_busy_cycles", 32'(bz), 32'd0);
        chk("idle_frame_cont", oFrame_Cont, 32'(frames));
    endtask

    task automatic start(input logic [1:0] mode, input logic stop);
        @(negedge iCLK);
        iMODE  = mode;
        iSTART = 1'b1;
        iSTOP  = stop;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge iCLK);
        chk("rst_outputs", 32'({oFVAL, oLVAL, oBUSY, oDATA}), 32'd0);
        chk("rst_frame_cont", oFrame_Cont, 32'd0);
        iRST_N = 1'b1;
        idle_check(4);

        // Basic timing, then a stop requested mid-frame 2 (stray iSTART ignored)
        start(2'd0, 1'b0);
        run_frame(0, -1, -1, -1, 2'd0);
        run_frame(0, 20, 30, -1, 2'd0);
        idle_check(20);

        // Mode latched at frame start; the mid-frame change shows up next frame
        start(2'd2, 1'b0);
        run_frame(2, -1, -1, 10, 2'd0);
        run_frame(0, 10, -1, -1, 2'd0);
        idle_check(10);

        // Mode 3 over two frames
        start(2'd3, 1'b0);
        run_frame(3, -1, -1, -1, 2'd0);
        run_frame(3, 25, -1, -1, 2'd0);
        idle_check(10);

        // Start and stop together from IDLE: exactly one frame
        start(2'd1, 1'b1);
        run_frame(1, -1, -1, -1, 2'd0);
        idle_check(30);

        // Asynchronous reset in the middle of a line
        start(2'd0, 1'b0);
        repeat (6) begin
            @(negedge iCLK);
            iSTART = 1'b0;
        end
        chk("pre_rst_lval", 32'(oLVAL), 32'd1);
        chk("pre_rst_x", 32'(oX_Cont), 32'd2);
        #2 iRST_N = 1'b0;
        #1;
        chk("async_rst_ctl", 32'({oFVAL, oLVAL, oBUSY}), 32'd0);
        chk("async_rst_data", 32'(oDATA), 32'd0);
        chk("async_rst_xy", {oX_Cont, oY_Cont}, 32'd0);
        chk("async_rst_frame_cont", oFrame_Cont, 32'd0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        frames = 0;
        idle_check(15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
